// File: rtl/nibble_add_sched_if.sv
// Purpose: request, external-adder and result signals of the nibble add scheduler.
// Latency: none, wiring only.
// Backpressure: requests are held by the requester until its one-cycle grant.
interface nibble_add_sched_if;
   logic        req0;
   logic        req1;
   logic [15:0] a0;
   logic [15:0] b0;
   logic [15:0] a1;
   logic [15:0] b1;
   logic        cin0;
   logic        cin1;
   logic        gnt0;
   logic        gnt1;
   logic [3:0]  add_a;
   logic [3:0]  add_b;
   logic        add_cin;
   logic [3:0]  add_sum;
   logic        add_cout;
   logic [15:0] result;
   logic        cout;
   logic        done;
   logic        done_id;
   logic        busy;

   modport master (
      output req0, req1, a0, b0, a1, b1, cin0, cin1, add_sum, add_cout,
      input  gnt0, gnt1, add_a, add_b, add_cin, result, cout, done, done_id, busy
   );

   modport slave (
      input  req0, req1, a0, b0, a1, b1, cin0, cin1, add_sum, add_cout,
      output gnt0, gnt1, add_a, add_b, add_cin, result, cout, done, done_id, busy
   );
endinterface

// File: rtl/nibble_add_sched.sv
// Purpose: round-robin two-requester 16-bit adder built on a shared external 4-bit adder.
// Latency: accept at E0, grant pulse E0-E1, done pulse E4-E5, next accept possible at E5.
// Backpressure: requests stay pending while busy; only the winner sees a grant.
module nibble_add_sched (
   input logic               clk,
   input logic               rst_n,
   nibble_add_sched_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] a_lat_q, a_lat_d;
   logic [15:0] b_lat_q, b_lat_d;
   logic        carry_q, carry_d;
   logic [15:0] work_q, work_d;
   logic [15:0] result_q, result_d;
   logic        cout_q, cout_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic        gnt0_q, gnt0_d;
   logic        gnt1_q, gnt1_d;

   logic        accept;
   logic        win1;
   logic [3:0]  nib_lo;

   // DONE also accepts so a waiting request is taken at E5 without an idle gap.
   assign accept = ((state_q == IDLE) || (state_q == DONE)) && (bus.req0 || bus.req1);
   // last_q=1 after reset, so requester 0 wins the first tie.
   assign win1   = bus.req1 && (!bus.req0 || !last_q);
   assign nib_lo = {idx_q, 2'b00};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (idx_q == 2'd3) state_d = DONE;
         DONE:    state_d = accept ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: adder drive only in RUN, status decoded from state
   always_comb begin
      bus.add_a   = 4'd0;
      bus.add_b   = 4'd0;
      bus.add_cin = 1'b0;
      if (state_q == RUN) begin
         bus.add_a   = a_lat_q[nib_lo +: 4];
         bus.add_b   = b_lat_q[nib_lo +: 4];
         bus.add_cin = carry_q;
      end
      bus.done    = (state_q == DONE);
      bus.done_id = (state_q == DONE) && owner_q;
      bus.busy    = (state_q != IDLE);
      bus.gnt0    = gnt0_q;
      bus.gnt1    = gnt1_q;
      bus.result  = result_q;
      bus.cout    = cout_q;
   end

   // Datapath next values: operand latch on accept, nibble capture in RUN
   always_comb begin
      idx_d    = idx_q;
      a_lat_d  = a_lat_q;
      b_lat_d  = b_lat_q;
      carry_d  = carry_q;
      work_d   = work_q;
      result_d = result_q;
      cout_d   = cout_q;
      owner_d  = owner_q;
      last_d   = last_q;
      gnt0_d   = 1'b0;
      gnt1_d   = 1'b0;
      if (accept) begin
         a_lat_d = win1 ? bus.a1 : bus.a0;
         b_lat_d = win1 ? bus.b1 : bus.b0;
         carry_d = win1 ? bus.cin1 : bus.cin0;
         idx_d   = 2'd0;
         owner_d = win1;
         last_d  = win1;
         gnt0_d  = !win1;
         gnt1_d  = win1;
      end else if (state_q == RUN) begin
         work_d[nib_lo +: 4] = bus.add_sum;
         carry_d = bus.add_cout;
         idx_d   = idx_q + 2'd1;
         // Partial sums stay in work_q; result only changes as the add completes.
         if (idx_q == 2'd3) begin
            result_d = {bus.add_sum, work_q[11:0]};
            cout_d   = bus.add_cout;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q    <= 2'd0;
         a_lat_q  <= 16'd0;
         b_lat_q  <= 16'd0;
         carry_q  <= 1'b0;
         work_q   <= 16'd0;
         result_q <= 16'd0;
         cout_q   <= 1'b0;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
      end else begin
         idx_q    <= idx_d;
         a_lat_q  <= a_lat_d;
         b_lat_q  <= b_lat_d;
         carry_q  <= carry_d;
         work_q   <= work_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
      end
   end

endmodule

// File: tb/tb_nibble_add_sched.sv
// Purpose: scoreboard bench for nibble_add_sched with a behavioural 4-bit adder.
// Latency: expects done exactly four cycles after each grant cycle.
// Backpressure: requests held until granted, then dropped.
module tb_nibble_add_sched;

   logic clk;
   logic rst_n;
   nibble_add_sched_if bus();

   nibble_add_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // External combinational ripple adder
   assign {bus.add_cout, bus.add_sum} = bus.add_a + bus.add_b + {3'd0, bus.add_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        id;
      logic [15:0] res;
      logic        co;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          lat = 0;
   bit          pending = 0;
   logic [15:0] last_res = 16'd0;
   logic        last_co = 1'b0;
   int          cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every done pulse
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         pending  = 0;
         last_res = 16'd0;
         last_co  = 1'b0;
      end else begin
         if (bus.gnt0 && bus.gnt1) check("gnt_overlap", 1, 0);
         if (bus.gnt0 || bus.gnt1) begin
            pending = 1;
            lat = 0;
         end else if (pending) begin
            lat++;
         end
         if (bus.done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("result", bus.result, e.res);
               check("cout", bus.cout, e.co);
               check("done_id", bus.done_id, e.id);
               check("latency", lat, 4);
            end
            last_res = bus.result;
            last_co  = bus.cout;
            pending  = 0;
         end else if (bus.busy) begin
            check("result_hold", {bus.cout, bus.result}, {last_co, last_res});
         end else begin
            check("idle_adder_zero", {bus.add_a, bus.add_b, bus.add_cin}, 0);
         end
      end
   end

   task automatic push(input logic id, input logic [15:0] res, input logic co);
      exp_t e;
      e.id = id; e.res = res; e.co = co;
      sb.push_back(e);
   endtask

   // Raise one request, hold until granted (bounded), then drop it
   task automatic do_req(input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic ci);
      bit got;
      @(negedge clk);
      if (id) begin bus.a1 = a; bus.b1 = b; bus.cin1 = ci; bus.req1 = 1'b1; end
      else    begin bus.a0 = a; bus.b0 = b; bus.cin0 = ci; bus.req0 = 1'b0 | 1'b1; end
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         #1;
         if ((id && bus.gnt1) || (!id && bus.gnt0)) got = 1;
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      if (!got) check("grant_timeout", 0, 1);
   endtask

   // Directed vectors: id, a, b, cin, expected result, expected cout
   typedef struct {
      logic        id;
      logic [15:0] a;
      logic [15:0] b;
      logic        ci;
      logic [15:0] res;
      logic        co;
   } vec_t;

   vec_t vecs[5];
   int   g_order[3];
   int   g_cyc[3];

   initial begin
      vecs[0] = '{1'b0, 16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0};
      vecs[1] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vecs[2] = '{1'b0, 16'h0008, 16'h0003, 1'b1, 16'h000C, 1'b0};
      vecs[3] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
      vecs[4] = '{1'b1, 16'h1234, 16'h5678, 1'b1, 16'h68AD, 1'b0};

      bus.req0 = 0; bus.req1 = 0;
      bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0; bus.cin0 = 0; bus.cin1 = 0;
      rst_n = 1'b0;
      #1;
      check("rst_outputs", {bus.gnt0, bus.gnt1, bus.done, bus.done_id, bus.busy,
                            bus.cout, bus.add_a, bus.add_b, bus.add_cin}, 0);
      check("rst_result", bus.result, 16'h0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single requests, back to back
      foreach (vecs[i]) begin
         push(vecs[i].id, vecs[i].res, vecs[i].co);
         do_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].ci);
      end
      repeat (6) @(negedge clk);

      // Both requesters held from reset: expect 0, 1, 0 with 5-cycle grant spacing
      rst_n = 1'b0;
      bus.a0 = 16'h0001; bus.b0 = 16'h0000; bus.cin0 = 1'b0;
      bus.a1 = 16'hFFFF; bus.b1 = 16'h0001; bus.cin1 = 1'b0;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      push(1'b0, 16'h0001, 1'b0);
      push(1'b1, 16'h0000, 1'b1);
      push(1'b0, 16'h0001, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int n;
         n = 0;
         for (int k = 0; k < 40 && n < 3; k++) begin
            @(negedge clk);
            #1;
            if (bus.gnt0 || bus.gnt1) begin
               g_order[n] = bus.gnt1 ? 1 : 0;
               g_cyc[n]   = cyc;
               n++;
            end
         end
         bus.req0 = 1'b0; bus.req1 = 1'b0;
         check("rr_grant_count", n, 3);
         if (n == 3) begin
            check("rr_first", g_order[0], 0);
            check("rr_second", g_order[1], 1);
            check("rr_third", g_order[2], 0);
            check("rr_spacing", g_cyc[1] - g_cyc[0], 5);
         end
      end
      repeat (6) @(negedge clk);

      // Give result a nonzero value, then abort a later add two edges into RUN
      push(1'b1, 16'h68AD, 1'b0);
      do_req(1'b1, 16'h1234, 16'h5678, 1'b1);
      repeat (6) @(negedge clk);
      do_req(1'b0, 16'h1234, 16'h1111, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_outputs", {bus.gnt0, bus.gnt1, bus.done, bus.done_id, bus.busy,
                              bus.cout, bus.add_a, bus.add_b, bus.add_cin}, 0);
      check("abort_result", bus.result, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      push(1'b0, 16'h1000, 1'b0);
      do_req(1'b0, 16'h0F0F, 16'h00F1, 1'b0);
      repeat (8) @(negedge clk);

      check("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
